// File: rtl/tl_pkg.sv
// Shared lamp encodings and controller state codes for the timed traffic light.
package tl_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5,
    WALK   = 3'd6
  } state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: clears on request, otherwise counts one per cycle.
// Latency: count visible the cycle after the edge; no backpressure (free-running).
// Backpressure: none, the owner decides when to clear.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] tmr
);

  always_ff @(posedge clk) begin
    if (reset || clr) tmr <= '0;
    else              tmr <= tmr + CNT_W'(1);
  end

endmodule

// File: rtl/tl_cntr_timed.sv
// Two-road traffic light with min/max green, yellow, all-red and pedestrian WALK phases.
// Latency: lamps follow the state register, changing the cycle after a transition edge.
// Backpressure: none; sensors and ped_req are sampled every cycle.
module tl_cntr_timed
  import tl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 8,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] RED_END  = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] WALK_END = CNT_W'(WALK_TIME - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmr;
  logic             ped_pend;
  logic             nxt_b;
  logic             enter_walk;

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_nxt != state),
    .tmr   (tmr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN:  if (tmr >= GMIN_END && (!Ta || tmr == GMAX_END)) state_nxt = A_YEL;
      A_YEL:  if (tmr == YEL_END) state_nxt = RED_AB;
      RED_AB: if (tmr == RED_END) state_nxt = ped_pend ? WALK : B_GRN;
      B_GRN:  if (tmr >= GMIN_END && (!Tb || tmr == GMAX_END)) state_nxt = B_YEL;
      B_YEL:  if (tmr == YEL_END) state_nxt = RED_BA;
      RED_BA: if (tmr == RED_END) state_nxt = ped_pend ? WALK : A_GRN;
      WALK:   if (tmr == WALK_END) state_nxt = nxt_b ? B_GRN : A_GRN;
      default: state_nxt = A_GRN;
    endcase
  end

  assign enter_walk = (state_nxt == WALK) && (state != WALK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= A_GRN;
      ped_pend <= 1'b0;
      nxt_b    <= 1'b1;
    end else begin
      state <= state_nxt;
      // Entering WALK consumes the request even if the button is still held.
      if (enter_walk)                    ped_pend <= 1'b0;
      else if (ped_req && state != WALK) ped_pend <= 1'b1;
      if (enter_walk) nxt_b <= (state == RED_AB);
    end
  end

  always_comb begin
    La   = LT_RED;
    Lb   = LT_RED;
    walk = 1'b0;
    case (state)
      A_GRN:   La   = LT_GREEN;
      A_YEL:   La   = LT_YELLOW;
      B_GRN:   Lb   = LT_GREEN;
      B_YEL:   Lb   = LT_YELLOW;
      WALK:    walk = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// Directed phase sequences for tl_cntr_timed, checked by a cycle-stamped scoreboard.
module tb_tl_cntr_timed;

  logic       clk = 1'b0;
  logic       reset;
  logic       Ta, Tb, ped_req;
  logic [1:0] La, Lb;
  logic       walk;
  logic [2:0] phase;

  tl_cntr_timed dut (
    .clk     (clk),
    .reset   (reset),
    .Ta      (Ta),
    .Tb      (Tb),
    .ped_req (ped_req),
    .La      (La),
    .Lb      (Lb),
    .walk    (walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ph;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Lamp table straight from the state code list: {La, Lb, walk}.
  function automatic logic [4:0] lamps(input logic [2:0] p);
    case (p)
      3'd0:    return {2'b00, 2'b10, 1'b0};
      3'd1:    return {2'b01, 2'b10, 1'b0};
      3'd3:    return {2'b10, 2'b00, 1'b0};
      3'd4:    return {2'b10, 2'b01, 1'b0};
      3'd6:    return {2'b10, 2'b10, 1'b1};
      default: return {2'b10, 2'b10, 1'b0};
    endcase
  endfunction

  // Monitor: pops every expectation whose cycle stamp has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [7:0] act, req;
      e = q.pop_front();
      total++;
      act = {La, Lb, walk, phase};
      req = {lamps(e.ph), e.ph};
      if (e.cyc != cyc)
        $display("FAIL %s cycle %0d: expectation for cycle %0d arrived late", e.tag, cyc, e.cyc);
      else if (act !== req)
        $display("FAIL %s cycle %0d: {La,Lb,walk,phase} got %b_%b_%b_%0d want %b_%b_%b_%0d",
                 e.tag, cyc, La, Lb, walk, phase, req[7:6], req[5:4], req[3], req[2:0]);
      else
        passed++;
    end
  end

  // Queue one expected phase per cycle starting now, then advance that many cycles.
  task automatic run(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) begin
      exp_t e;
      e.cyc = cyc + i;
      e.ph  = 3'(s[i] - 8'd48);
      e.tag = tag;
      q.push_back(e);
    end
    repeat (s.len()) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Ta = 1'b0; Tb = 1'b0; ped_req = 1'b0;
    @(posedge clk); #1;

    // Reset held for two edges.
    run("reset", "0");
    reset = 1'b0;

    // Idle roads: 14-cycle period at minimum green.
    run("idle", "00001123333445");
    run("idle2", "00001123333445");

    // Ta held: A green runs to the maximum.
    Ta = 1'b1;
    run("gmax", "00000000");
    run("gmax_tail", "1123333445");
    // Ta drops in the fifth green cycle.
    run("gdrop", "0000");
    Ta = 1'b0;
    run("gdrop5", "0");
    run("gdrop_tail", "1123333445");

    // Single-cycle press in A green, another press during WALK is ignored.
    ped_req = 1'b1;
    run("ped_a", "0");
    ped_req = 1'b0;
    run("ped_a", "000112");
    ped_req = 1'b1;
    run("walk_ab", "666");
    ped_req = 1'b0;
    run("after_walk_ab", "3333445");
    run("no_rewalk", "0000112");

    // Press in B green: WALK after RED_BA, then back to A.
    ped_req = 1'b1;
    run("ped_b", "3");
    ped_req = 1'b0;
    run("ped_b", "333445");
    run("walk_ba", "666");
    run("after_walk_ba", "0000112");

    // Reset in the first B yellow cycle drops the pending request.
    ped_req = 1'b1;
    run("rst_mid", "3");
    ped_req = 1'b0;
    run("rst_mid", "333");
    reset = 1'b1;
    run("rst_byel", "4");
    reset = 1'b0;
    run("rst_after", "00001123333");

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
